// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: prescaled pixel tick, h/v counters,
// registered syncs, display-enable, active-area coordinates and start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic             vga_h_sync,
  output logic             vga_v_sync,
  output logic             in_display_area,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_AST    = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_AST    = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_AEND   = CNT_W'(H_TOTAL - H_FRONT);
  localparam logic [CNT_W-1:0] V_AEND   = CNT_W'(V_TOTAL - V_FRONT);

  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             pe_q, pe_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic             tick, h_act, v_act;

  assign tick  = (div_q == DIV_LAST);
  assign h_act = (h_q >= H_AST) && (h_q < H_AEND);
  assign v_act = (v_q >= V_AST) && (v_q < V_AEND);

  // Outputs are computed from the pre-increment counters, so they trail h/v by one tick.
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    pe_d  = tick;
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    x_d   = x_q;
    y_d   = y_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (tick) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + CNT_W'(1);
      if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      hs_d = (h_q < H_SYNC_C) ? HS_POL : ~HS_POL;
      vs_d = (v_q < V_SYNC_C) ? VS_POL : ~VS_POL;
      de_d = h_act && v_act;
      x_d  = (h_act && v_act) ? h_q - H_AST : '0;
      y_d  = (h_act && v_act) ? v_q - V_AST : '0;
      ls_d = (h_q == '0);
      fs_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      pe_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      pe_q  <= pe_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      x_q   <= x_d;
      y_q   <= y_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign pix_en          = pe_q;
  assign vga_h_sync      = hs_q;
  assign vga_v_sync      = vs_q;
  assign in_display_area = de_q;
  assign pix_x           = x_q;
  assign pix_y           = y_q;
  assign line_start      = ls_q;
  assign frame_start     = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a small active-high
// geometry at CLK_DIV=1, and the same small geometry at CLK_DIV=2.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  always #5 clk = ~clk;

  logic pe0, hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic pe1, hs1, vs1, de1, ls1, fs1;
  logic [3:0] x1, y1;
  logic pe2, hs2, vs2, de2, ls2, fs2;
  logic [3:0] x2, y2;

  vga_timing_gen u0 (
    .clk(clk), .reset(rst0), .pix_en(pe0), .vga_h_sync(hs0), .vga_v_sync(vs0),
    .in_display_area(de0), .pix_x(x0), .pix_y(y0), .line_start(ls0), .frame_start(fs0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(2), .CNT_W(4)
  ) u1 (
    .clk(clk), .reset(rst1), .pix_en(pe1), .vga_h_sync(hs1), .vga_v_sync(vs1),
    .in_display_area(de1), .pix_x(x1), .pix_y(y1), .line_start(ls1), .frame_start(fs1));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CNT_W(4)
  ) u2 (
    .clk(clk), .reset(rst2), .pix_en(pe2), .vga_h_sync(hs2), .vga_v_sync(vs2),
    .in_display_area(de2), .pix_x(x2), .pix_y(y2), .line_start(ls2), .frame_start(fs2));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  localparam int L = 28800;  // 36 default lines: reaches the first active row (v=35)

  initial begin
    int last_ls0, nls0, nhs0, nvs0, nfs0, nde0, nbad0, last_fs2;
    int h, v, k, lines, period;
    logic ede, found;
    last_ls0 = 0; nls0 = 0; nhs0 = 0; nvs0 = 0; nfs0 = 0; nde0 = 0; nbad0 = 0;
    last_fs2 = 0;

    repeat (3) @(negedge clk);
    chk("u0_rst_hs", hs0, 1);  chk("u0_rst_vs", vs0, 1);  chk("u0_rst_de", de0, 0);
    chk("u0_rst_x", x0, 0);    chk("u0_rst_y", y0, 0);    chk("u0_rst_pe", pe0, 0);
    chk("u0_rst_ls", ls0, 0);  chk("u0_rst_fs", fs0, 0);
    chk("u2_rst_hs", hs2, 0);  chk("u2_rst_vs", vs2, 0);  chk("u1_rst_hs", hs1, 1);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    for (int n = 1; n <= L; n++) begin
      @(negedge clk);
      // default geometry
      if (ls0) begin
        if (last_ls0 > 0) chk("u0_ls_period", n - last_ls0, 800);
        last_ls0 = n; nls0++;
      end
      if (n <= 800 && !hs0) nhs0++;
      if (!vs0) nvs0++;
      if (fs0) nfs0++;
      if (de0) nde0++;
      if (!de0 && (x0 != 0 || y0 != 0)) nbad0++;
      if (n == 1) begin
        chk("u0_first_fs", fs0, 1); chk("u0_first_ls", ls0, 1); chk("u0_first_hs", hs0, 0);
        chk("u0_first_vs", vs0, 0); chk("u0_first_de", de0, 0); chk("u0_first_pe", pe0, 1);
      end
      if (n == 28144) begin chk("u0_pre_act_de", de0, 0); chk("u0_pre_act_x", x0, 0); end
      if (n == 28145) begin
        chk("u0_act0_de", de0, 1); chk("u0_act0_x", x0, 0); chk("u0_act0_y", y0, 0);
      end
      if (n == 28784) begin
        chk("u0_last_x", x0, 639); chk("u0_last_y", y0, 0); chk("u0_last_de", de0, 1);
      end
      if (n == 28785) begin chk("u0_post_de", de0, 0); chk("u0_post_x", x0, 0); end

      // small active-high geometry, one tick per clk
      if (fs2) begin
        if (last_fs2 > 0) chk("u2_fs_period", n - last_fs2, 84);
        last_fs2 = n;
      end
      if (n <= 200) begin
        h = (n - 1) % 12; v = ((n - 1) / 12) % 7;
        ede = (h >= 3 && h < 11 && v >= 2 && v < 6);
        chk("u2_hs", hs2, (h < 2) ? 1 : 0);
        chk("u2_vs", vs2, (v < 1) ? 1 : 0);
        chk("u2_de", de2, ede);
        chk("u2_x", x2, ede ? h - 3 : 0);
        chk("u2_y", y2, ede ? v - 2 : 0);
        chk("u2_ls", ls2, (h == 0) ? 1 : 0);
        chk("u2_fs", fs2, (h == 0 && v == 0) ? 1 : 0);
      end

      // small geometry at CLK_DIV=2: tick k lands on even samples
      if (n <= 400) begin
        k = n / 2;
        chk("u1_pe", pe1, (n % 2 == 0) ? 1 : 0);
        if (k == 0) begin
          chk("u1_init_hs", hs1, 1); chk("u1_init_de", de1, 0); chk("u1_init_fs", fs1, 0);
        end else begin
          h = (k - 1) % 12; v = ((k - 1) / 12) % 7;
          ede = (h >= 3 && h < 11 && v >= 2 && v < 6);
          chk("u1_hs", hs1, (h < 2) ? 0 : 1);
          chk("u1_vs", vs1, (v < 1) ? 0 : 1);
          chk("u1_de", de1, ede);
          chk("u1_x", x1, ede ? h - 3 : 0);
          chk("u1_y", y1, ede ? v - 2 : 0);
          chk("u1_ls", ls1, (n % 2 == 0 && h == 0) ? 1 : 0);
          chk("u1_fs", fs1, (n % 2 == 0 && h == 0 && v == 0) ? 1 : 0);
        end
      end
    end

    chk("u0_ls_count", nls0, 36);
    chk("u0_hs_low_line0", nhs0, 96);
    chk("u0_vs_low", nvs0, 1600);
    chk("u0_fs_count", nfs0, 1);
    chk("u0_de_count", nde0, 640);
    chk("u0_coord_outside", nbad0, 0);

    // advance u2 to h=6, v=3 (pix_x=3, pix_y=1) and reset it mid-frame
    repeat (55) @(negedge clk);
    chk("u2_mid_de", de2, 1); chk("u2_mid_x", x2, 3); chk("u2_mid_y", y2, 1);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("u2_mrst_hs", hs2, 0); chk("u2_mrst_vs", vs2, 0); chk("u2_mrst_de", de2, 0);
    chk("u2_mrst_x", x2, 0);   chk("u2_mrst_y", y2, 0);   chk("u2_mrst_fs", fs2, 0);
    chk("u2_mrst_ls", ls2, 0); chk("u1_mrst_pe", pe1, 0); chk("u1_mrst_hs", hs1, 1);
    rst1 = 1'b1; rst2 = 1'b1;

    lines = 0; period = 0; found = 1'b0;
    for (int j = 1; j <= 200 && !found; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk("u2_rel_fs", fs2, 1); chk("u2_rel_ls", ls2, 1);
        chk("u2_rel_hs", hs2, 1); chk("u2_rel_vs", vs2, 1);
        chk("u1_rel1_pe", pe1, 0); chk("u1_rel1_fs", fs1, 0);
        lines = 1;
      end else begin
        if (j == 2) begin chk("u1_rel2_pe", pe1, 1); chk("u1_rel2_fs", fs1, 1); end
        if (j == 3) chk("u1_rel3_fs", fs1, 0);
        if (fs2) begin found = 1'b1; period = j - 1; end
        else if (ls2) lines++;
      end
    end
    chk("u2_next_fs_found", found, 1);
    chk("u2_lines_per_frame", lines, 7);
    chk("u2_frame_period", period, 84);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
